// File: rtl/mt9v034_vid2axis.sv
// rtl/mt9v034_vid2axis.sv - MT9V034 parallel video to AXI4-Stream bridge
// One-pixel hold register decides tlast, then a first-word-fall-through FIFO feeds the stream.
module mt9v034_vid2axis #(
  parameter int FIFO_DEPTH      = 16,
  parameter int VIDEO_BIT_WIDTH = 8
) (
  input  logic                       pxclk,
  input  logic                       reset,
  input  logic                       receiver_locked,
  input  logic                       pixel_data_valid,
  input  logic                       vid_active_video,
  input  logic [VIDEO_BIT_WIDTH-1:0] vid_data,
  input  logic                       vid_hblank,
  input  logic                       vid_vblank,
  output logic [VIDEO_BIT_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       overflow,
  output logic [15:0]                frame_count,
  output logic [10:0]                line_width,
  output logic [9:0]                 line_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = VIDEO_BIT_WIDTH + 2;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [2:0] {WAIT_LOCK, WAIT_VBLANK, WAIT_FRAME, ACTIVE, DROP} state_t;

  state_t                     state_q, state_d;
  logic                       hold_vld_q, hold_vld_d;
  logic                       hold_sof_q, hold_sof_d;
  logic [VIDEO_BIT_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [EW-1:0]              mem_q [FIFO_DEPTH];
  logic [EW-1:0]              mem_d [FIFO_DEPTH];
  logic [AW:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                       overflow_q, overflow_d;
  logic [15:0]                frame_count_q, frame_count_d;
  logic [10:0]                line_width_q, line_width_d, pix_cnt_q, pix_cnt_d;
  logic [9:0]                 line_count_q, line_count_d, lines_q, lines_d;

  logic          empty, full, pop, push_req, push_last, push_ok, is_pixel, frame_end;
  logic [EW-1:0] rd_entry;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign pop      = !empty && m_axis_tready;
  assign is_pixel = vid_active_video && !vid_hblank && !vid_vblank;

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : rd_entry[VIDEO_BIT_WIDTH-1:0];
  assign m_axis_tuser  = !empty && rd_entry[VIDEO_BIT_WIDTH+1];
  assign m_axis_tlast  = !empty && rd_entry[VIDEO_BIT_WIDTH];
  assign overflow      = overflow_q;
  assign frame_count   = frame_count_q;
  assign line_width    = line_width_q;
  assign line_count    = line_count_q;

  always_comb begin
    state_d       = state_q;
    hold_vld_d    = hold_vld_q;
    hold_sof_d    = hold_sof_q;
    hold_data_d   = hold_data_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    line_width_d  = line_width_q;
    pix_cnt_d     = pix_cnt_q;
    line_count_d  = line_count_q;
    lines_d       = lines_q;
    push_req      = 1'b0;
    push_last     = 1'b0;
    push_ok       = 1'b0;
    frame_end     = 1'b0;

    if (!receiver_locked) begin
      state_d    = WAIT_LOCK;
      hold_vld_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK:   state_d = WAIT_VBLANK;
        WAIT_VBLANK: if (pixel_data_valid && vid_vblank) state_d = WAIT_FRAME;
        WAIT_FRAME: begin
          if (pixel_data_valid && is_pixel) begin
            state_d     = ACTIVE;
            hold_vld_d  = 1'b1;
            hold_sof_d  = 1'b1;
            hold_data_d = vid_data;
            pix_cnt_d   = '0;
            lines_d     = '0;
          end
        end
        ACTIVE: begin
          // The incoming sample decides whether the held pixel ends its line.
          if (pixel_data_valid) begin
            push_req    = hold_vld_q;
            push_last   = !is_pixel;
            hold_vld_d  = is_pixel;
            hold_sof_d  = 1'b0;
            hold_data_d = vid_data;
            if (vid_vblank) begin
              state_d   = WAIT_FRAME;
              frame_end = 1'b1;
            end
          end
        end
        DROP:    if (pixel_data_valid && vid_vblank) state_d = WAIT_FRAME;
        default: state_d = WAIT_LOCK;
      endcase
    end

    push_ok = push_req && (!full || pop);
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = {hold_sof_q, push_last, hold_data_q};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (hold_sof_q) frame_count_d = frame_count_q + 16'd1;
      if (push_last) begin
        line_width_d = (pix_cnt_q == 11'h7FF) ? 11'h7FF : pix_cnt_q + 11'd1;
        pix_cnt_d    = '0;
        lines_d      = (lines_q == 10'h3FF) ? lines_q : lines_q + 10'd1;
      end else if (pix_cnt_q != 11'h7FF) begin
        pix_cnt_d = pix_cnt_q + 11'd1;
      end
    end else if (push_req) begin
      overflow_d = 1'b1;
      state_d    = DROP;
      hold_vld_d = 1'b0;
    end

    if (frame_end && state_d != DROP) line_count_d = lines_d;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      state_q       <= WAIT_LOCK;
      hold_vld_q    <= 1'b0;
      hold_sof_q    <= 1'b0;
      hold_data_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
      line_width_q  <= '0;
      pix_cnt_q     <= '0;
      line_count_q  <= '0;
      lines_q       <= '0;
    end else begin
      state_q       <= state_d;
      hold_vld_q    <= hold_vld_d;
      hold_sof_q    <= hold_sof_d;
      hold_data_q   <= hold_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
      line_width_q  <= line_width_d;
      pix_cnt_q     <= pix_cnt_d;
      line_count_q  <= line_count_d;
      lines_q       <= lines_d;
    end
  end

  // Storage needs no reset: empty pointers make every entry invisible.
  always_ff @(posedge pxclk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_mt9v034_vid2axis.sv
// tb/tb_mt9v034_vid2axis.sv - self-checking bench for mt9v034_vid2axis
// Expected beats come from frame/line descriptions; one negedge process compares every delivered beat.
module tb_mt9v034_vid2axis;
  localparam int DEPTH = 16;
  localparam int W     = 8;

  logic         pxclk = 1'b0;
  logic         reset, receiver_locked, pixel_data_valid, vid_active_video, vid_hblank, vid_vblank;
  logic [W-1:0] vid_data, m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast, overflow;
  logic [15:0]  frame_count;
  logic [10:0]  line_width;
  logic [9:0]   line_count;

  int checks = 0;
  int errors = 0;
  int gap = 0;
  int tready_mode = 0;
  int exp_fc = 0, exp_lw = 0, exp_lc = 0, exp_ovf = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_log[$];

  always #5 pxclk = ~pxclk;

  mt9v034_vid2axis #(.FIFO_DEPTH(DEPTH), .VIDEO_BIT_WIDTH(W)) dut (
    .pxclk(pxclk), .reset(reset), .receiver_locked(receiver_locked),
    .pixel_data_valid(pixel_data_valid), .vid_active_video(vid_active_video),
    .vid_data(vid_data), .vid_hblank(vid_hblank), .vid_vblank(vid_vblank),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .overflow(overflow),
    .frame_count(frame_count), .line_width(line_width), .line_count(line_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0: always ready, 1: never ready, 2: toggle every cycle
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge pxclk);
      #1;
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'b0;
        default: m_axis_tready = ~m_axis_tready;
      endcase
    end
  end

  initial begin
    logic       stalled;
    logic [9:0] stall_beat, beat;
    stalled = 1'b0;
    forever begin
      @(negedge pxclk);
      beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (!reset && m_axis_tvalid) begin
        if (stalled) chk("stall_stable", beat, stall_beat);
        if (m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none", beat);
          end else begin
            chk("beat", beat, exp_q.pop_front());
          end
          got_log.push_back(beat);
          stalled = 1'b0;
        end else begin
          stalled    = 1'b1;
          stall_beat = beat;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic step(input bit v, input bit a, input logic [W-1:0] d, input bit hb, input bit vb);
    pixel_data_valid = v;
    vid_active_video = a;
    vid_data         = d;
    vid_hblank       = hb;
    vid_vblank       = vb;
    @(posedge pxclk);
    #1;
  endtask

  // Invalid cycles carry junk that looks like an active vblank pixel.
  task automatic sample(input bit a, input logic [W-1:0] d, input bit hb, input bit vb);
    step(1'b1, a, d, hb, vb);
    repeat (gap) step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
  endtask

  task automatic vblank_pair();
    sample(1'b0, 8'h00, 1'b0, 1'b1);
    sample(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic send_line(input logic [W-1:0] base, input int n, input bit first, input bit expect_out);
    logic [W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + W'(i);
      if (expect_out) exp_q.push_back({first && (i == 0), i == n - 1, d});
      sample(1'b1, d, 1'b0, 1'b0);
    end
    sample(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic frame(input logic [W-1:0] base, input int nlines, input int n);
    vblank_pair();
    for (int l = 0; l < nlines; l++) send_line(base + W'(l * 16), n, l == 0, 1'b1);
    vblank_pair();
    exp_fc++;
    exp_lw = n;
    exp_lc = nlines;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge pxclk);
      #1;
      n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk({name, "_idle_tvalid"}, m_axis_tvalid, 0);
  endtask

  task automatic counters(input string name);
    chk({name, "_frame_count"}, frame_count, exp_fc);
    chk({name, "_line_width"}, line_width, exp_lw);
    chk({name, "_line_count"}, line_count, exp_lc);
    chk({name, "_overflow"}, overflow, exp_ovf);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    receiver_locked = 1'b0;
    pixel_data_valid = 1'b0;
    vid_active_video = 1'b0;
    vid_data = '0;
    vid_hblank = 1'b0;
    vid_vblank = 1'b0;
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_tvalid", m_axis_tvalid, 0);
    counters("reset");

    reset = 1'b0;
    receiver_locked = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Basic two-line frame; literal pins on the first delivered beats.
    got_log.delete();
    frame(8'h10, 2, 4);
    drain("basic");
    counters("basic");
    chk("pin_sof", got_log[0], 10'h210);
    chk("pin_last0", got_log[3], 10'h113);
    chk("pin_line1", got_log[4], 10'h020);
    chk("pin_last1", got_log[7], 10'h123);
    chk("pin_count", got_log.size(), 8);

    // Same frame with a qualified sample only every third cycle.
    gap = 2;
    frame(8'h10, 2, 4);
    gap = 0;
    drain("sparse");
    counters("sparse");

    // Backpressure toggling every cycle.
    tready_mode = 2;
    frame(8'h30, 1, 4);
    drain("toggle");
    tready_mode = 0;
    counters("toggle");

    // Overflow: 20-pixel line with no drain keeps exactly the first DEPTH pixels.
    tready_mode = 1;
    vblank_pair();
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] d;
      d = 8'h40 + W'(i);
      if (i < DEPTH) exp_q.push_back({i == 0, 1'b0, d});
      sample(1'b1, d, 1'b0, 1'b0);
    end
    sample(1'b0, 8'h00, 1'b1, 1'b0);
    vblank_pair();
    exp_fc++;
    exp_ovf = 1;
    chk("ovf_tvalid_full", m_axis_tvalid, 1);
    counters("ovf");
    tready_mode = 0;
    drain("ovf");
    frame(8'h60, 2, 4);
    drain("after_ovf");
    counters("after_ovf");

    // Lock lost after the third pixel of a line.
    vblank_pair();
    exp_q.push_back(10'h280);
    exp_q.push_back(10'h081);
    sample(1'b1, 8'h80, 1'b0, 1'b0);
    sample(1'b1, 8'h81, 1'b0, 1'b0);
    sample(1'b1, 8'h82, 1'b0, 1'b0);
    receiver_locked = 1'b0;
    sample(1'b1, 8'h83, 1'b0, 1'b0);
    sample(1'b0, 8'h00, 1'b1, 1'b0);
    exp_fc++;
    receiver_locked = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_line(8'h90, 4, 1'b1, 1'b0);
    drain("unlock");
    counters("unlock");
    frame(8'hA0, 1, 3);
    drain("relock");
    counters("relock");

    // Reset pulsed mid-line with data stuck in the FIFO and hold register.
    tready_mode = 1;
    vblank_pair();
    sample(1'b1, 8'hB0, 1'b0, 1'b0);
    sample(1'b1, 8'hB1, 1'b0, 1'b0);
    sample(1'b1, 8'hB2, 1'b0, 1'b0);
    chk("pre_reset_tvalid", m_axis_tvalid, 1);
    reset = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_fc = 0; exp_lw = 0; exp_lc = 0; exp_ovf = 0;
    chk("midreset_tvalid", m_axis_tvalid, 0);
    counters("midreset");
    reset = 1'b0;
    tready_mode = 0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    frame(8'hC0, 1, 4);
    drain("post_reset");
    counters("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
